// File: rtl/sat_add_acc.sv
// Multi-lane saturating adder/accumulator with a 4-state handshake pipeline.
// Each beat passes through IDLE -> ADD -> SAT -> HOLD; lanes are independent.
module sat_add_acc #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   mode,
  input  logic                   clear_acc,
  input  logic [LANES*WIDTH-1:0] x,
  input  logic [LANES*WIDTH-1:0] y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] result,
  output logic [LANES-1:0]       sat_flags
);

  localparam int unsigned DW = LANES * WIDTH;
  localparam int unsigned SW = WIDTH + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_SAT  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [DW-1:0]     opx_q, opx_d;
  logic [DW-1:0]     opy_q, opy_d;
  logic              mode_q, mode_d;
  logic              clr_q, clr_d;
  logic [LANES*SW-1:0] sum_q, sum_d;
  logic [DW-1:0]     res_q, res_d;
  logic [LANES-1:0]  flg_q, flg_d;
  logic [DW-1:0]     acc_q, acc_d;
  logic              in_ready_q, out_valid_q;
  logic [WIDTH:0]    lane_a, lane_b, lane_s;

  // Next-state and datapath: ADD forms WIDTH+1 bit sums, SAT clamps them.
  always_comb begin
    state_d = state_q;
    opx_d   = opx_q;
    opy_d   = opy_q;
    mode_d  = mode_q;
    clr_d   = clr_q;
    sum_d   = sum_q;
    res_d   = res_q;
    flg_d   = flg_q;
    acc_d   = acc_q;
    lane_a  = '0;
    lane_b  = '0;
    lane_s  = '0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_ADD;
          opx_d   = x;
          opy_d   = y;
          mode_d  = mode;
          clr_d   = clear_acc;
        end
      end
      S_ADD: begin
        for (int i = 0; i < int'(LANES); i++) begin
          lane_a = {opx_q[i*WIDTH+WIDTH-1], opx_q[i*WIDTH +: WIDTH]};
          if (!mode_q) begin
            lane_b = {opy_q[i*WIDTH+WIDTH-1], opy_q[i*WIDTH +: WIDTH]};
          end else if (clr_q) begin
            lane_b = '0;
          end else begin
            lane_b = {acc_q[i*WIDTH+WIDTH-1], acc_q[i*WIDTH +: WIDTH]};
          end
          sum_d[i*SW +: SW] = lane_a + lane_b;
        end
        state_d = S_SAT;
      end
      S_SAT: begin
        // Top two sum bits differing means the lane left the WIDTH-bit range.
        for (int i = 0; i < int'(LANES); i++) begin
          lane_s = sum_q[i*SW +: SW];
          if (!lane_s[WIDTH] && lane_s[WIDTH-1]) begin
            res_d[i*WIDTH +: WIDTH] = MAX_V;
            flg_d[i]                = 1'b1;
          end else if (lane_s[WIDTH] && !lane_s[WIDTH-1]) begin
            res_d[i*WIDTH +: WIDTH] = MIN_V;
            flg_d[i]                = 1'b1;
          end else begin
            res_d[i*WIDTH +: WIDTH] = lane_s[WIDTH-1:0];
            flg_d[i]                = 1'b0;
          end
          if (mode_q) begin
            acc_d[i*WIDTH +: WIDTH] = res_d[i*WIDTH +: WIDTH];
          end
        end
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; handshake outputs track the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      opx_q       <= '0;
      opy_q       <= '0;
      mode_q      <= 1'b0;
      clr_q       <= 1'b0;
      sum_q       <= '0;
      res_q       <= '0;
      flg_q       <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      opx_q       <= opx_d;
      opy_q       <= opy_d;
      mode_q      <= mode_d;
      clr_q       <= clr_d;
      sum_q       <= sum_d;
      res_q       <= res_d;
      flg_q       <= flg_d;
      acc_q       <= acc_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_HOLD);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = res_q;
  assign sat_flags = flg_q;

endmodule
